// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc16_pkg
// Description : Shared state encoding, CRC-16 polynomial and byte-step function
//               used by the CRC-16 frame arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CRC_HI = 2'd2,
        ST_CRC_LO = 2'd3
    } arb_state_e;

    // MSB-first, non-reflected: the byte enters the top of the register, then 8 shifts.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int b = 0; b < 8; b++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_byte_step.sv
`default_nettype none
// ============================================================================
// Module      : crc16_byte_step
// Description : Combinational one-byte CRC-16 update (crc_q, data) -> crc_d.
// Revision    : 1.0  initial release
// ============================================================================
module crc16_byte_step
    import crc16_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    assign o_crc = crc16_next(i_crc, i_data);

endmodule
`default_nettype wire

// File: rtl/crc16_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crc16_frame_arbiter
// Description : Round-robin frame arbiter feeding one shared CRC-16 engine; passes
//               the granted requester's bytes through and appends a 2-byte trailer.
// Revision    : 1.0  initial release
// ============================================================================
module crc16_frame_arbiter
    import crc16_pkg::*;
#(
    parameter  int          NUM_REQ  = 4,
    parameter  logic [15:0] CRC_INIT = 16'h0000,
    localparam int          IDX_W    = $clog2(NUM_REQ)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_out_valid,
    output logic [7:0]             o_out_data,
    output logic                   o_out_last,
    input  logic                   i_out_ready,
    output logic [IDX_W-1:0]       o_out_src,
    output logic                   o_busy,
    output logic                   o_frame_done
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_DATA   = ST_DATA;
    localparam logic [1:0] S_CRC_HI = ST_CRC_HI;
    localparam logic [1:0] S_CRC_LO = ST_CRC_LO;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_src;
    logic [15:0]      r_crc;
    logic             r_frame_done;

    logic             w_lane_valid;
    logic [7:0]       w_lane_data;
    logic             w_lane_last;
    logic             w_accept;
    logic [15:0]      w_crc_next;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_ptr_next;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [IDX_W-1:0]     enc;
        logic [IDX_W:0]       sum;
        dbl = {valid, valid} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        enc = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) enc = IDX_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, enc};
        if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
        return sum[IDX_W-1:0];
    endfunction

    assign w_pick       = rr_pick(i_req_valid, r_rr_ptr);
    assign w_ptr_next   = (r_src == IDX_W'(NUM_REQ - 1)) ? '0 : r_src + 1'b1;
    assign w_lane_valid = i_req_valid[r_src];
    assign w_lane_data  = i_req_data[{r_src, 3'b000} +: 8];
    assign w_lane_last  = i_req_last[r_src];
    assign w_accept     = (r_state == S_DATA) && w_lane_valid && i_out_ready;

    crc16_byte_step u_crc_step (
        .i_crc  (r_crc),
        .i_data (w_lane_data),
        .o_crc  (w_crc_next)
    );

    always_comb begin
        o_req_ready = '0;
        o_out_valid = 1'b0;
        o_out_data  = 8'h00;
        o_out_last  = 1'b0;
        case (r_state)
            S_DATA: begin
                o_out_valid        = w_lane_valid;
                o_out_data         = w_lane_data;
                o_req_ready[r_src] = i_out_ready;
            end
            S_CRC_HI: begin
                o_out_valid = 1'b1;
                o_out_data  = r_crc[15:8];
            end
            S_CRC_LO: begin
                o_out_valid = 1'b1;
                o_out_data  = r_crc[7:0];
                o_out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_src        <= '0;
            r_crc        <= CRC_INIT;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req_valid) begin
                        r_src   <= w_pick;
                        r_crc   <= CRC_INIT;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_crc <= w_crc_next;
                        if (w_lane_last) r_state <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (i_out_ready) r_state <= S_CRC_LO;
                end
                S_CRC_LO: begin
                    if (i_out_ready) begin
                        r_frame_done <= 1'b1;
                        r_rr_ptr     <= w_ptr_next;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_src    = r_src;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc16_frame_arbiter
// Description : Directed self-checking bench for crc16_frame_arbiter (4 requesters).
// Revision    : 1.0  initial release
// ============================================================================
module tb_crc16_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_req_valid = '0;
    logic [31:0] i_req_data  = '0;
    logic [3:0]  i_req_last  = '0;
    logic [3:0]  o_req_ready;
    logic        o_out_valid;
    logic [7:0]  o_out_data;
    logic        o_out_last;
    logic        i_out_ready = 1'b0;
    logic [1:0]  o_out_src;
    logic        o_busy;
    logic        o_frame_done;

    crc16_frame_arbiter #(.NUM_REQ(4), .CRC_INIT(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .i_req_last   (i_req_last),
        .o_req_ready  (o_req_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .o_out_last   (o_out_last),
        .i_out_ready  (i_out_ready),
        .o_out_src    (o_out_src),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] lbuf [4][16];
    int         llen [4];
    int         lpos [4];
    int         lflen[4];
    bit         lhold[4];

    logic [7:0] obytes[64];
    logic [1:0] osrc  [64];
    logic       olast [64];
    int         ocyc  [64];
    int         ocnt, fd_cnt, cyc, stray, stall_bad;
    int         fd_cyc[8];
    bit         prev_stall;
    logic [7:0] prev_data;

    logic [7:0] check_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ocnt = 0; fd_cnt = 0; cyc = 0; stray = 0; stall_bad = 0; prev_stall = 0;
        for (int l = 0; l < 4; l++) begin
            llen[l] = 0; lpos[l] = 0; lflen[l] = 1; lhold[l] = 0;
        end
    endtask

    task automatic load_check(input int l);
        for (int k = 0; k < 9; k++) lbuf[l][k] = check_str[k];
        llen[l] = 9; lpos[l] = 0; lflen[l] = 9;
    endtask

    // One bus cycle: drive lanes from their buffers, sample, pop accepted bytes.
    task automatic cycle(input int mode);
        for (int l = 0; l < 4; l++) begin
            i_req_valid[l]      = (lpos[l] < llen[l]) && !lhold[l];
            i_req_data[8*l +: 8] = (lpos[l] < llen[l]) ? lbuf[l][lpos[l]] : 8'h00;
            i_req_last[l]       = ((lpos[l] + 1) % lflen[l]) == 0;
        end
        i_out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        #1;
        if (o_frame_done && fd_cnt < 8) begin
            fd_cyc[fd_cnt] = cyc;
            fd_cnt++;
        end
        if ($countones(o_req_ready) > 1) stray++;
        if (o_req_ready != 4'b0 && o_req_ready != (4'b0001 << o_out_src)) stray++;
        if (o_out_valid && !o_busy) stray++;
        if (prev_stall && o_out_valid && o_out_data !== prev_data) stall_bad++;
        prev_stall = o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        if (o_out_valid && i_out_ready && ocnt < 64) begin
            obytes[ocnt] = o_out_data;
            osrc[ocnt]   = o_out_src;
            olast[ocnt]  = o_out_last;
            ocyc[ocnt]   = cyc;
            ocnt++;
        end
        for (int l = 0; l < 4; l++) begin
            if (i_req_valid[l] && o_req_ready[l]) lpos[l]++;
        end
        tick();
        cyc++;
    endtask

    task automatic run_until_fd(input string tag, input int target, input int bound, input int mode);
        int n;
        n = 0;
        while (fd_cnt < target && n < bound) begin
            cycle(mode);
            n++;
        end
        chk({tag, "_frame_done_count"}, fd_cnt, target);
    endtask

    task automatic check_crc_frame(input string tag, input int base, input logic [1:0] src);
        for (int k = 0; k < 9; k++) chk($sformatf("%s_pay%0d", tag, k), obytes[base+k], check_str[k]);
        chk({tag, "_crc_hi"}, obytes[base+9], 8'hFE);
        chk({tag, "_crc_lo"}, obytes[base+10], 8'hE8);
        chk({tag, "_last_lo"}, olast[base+10], 1'b1);
        chk({tag, "_last_hi"}, olast[base+9], 1'b0);
        for (int k = 0; k < 11; k++) chk($sformatf("%s_src%0d", tag, k), osrc[base+k], src);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int nlast;

    initial begin
        clear_log();
        // reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_req_ready",  o_req_ready, 4'b0);
        chk("rst_out_valid",  o_out_valid, 1'b0);
        chk("rst_out_last",   o_out_last, 1'b0);
        chk("rst_busy",       o_busy, 1'b0);
        chk("rst_frame_done", o_frame_done, 1'b0);
        chk("rst_out_src",    o_out_src, 2'd0);

        // 1: single-byte frame from requester 0
        clear_log();
        lbuf[0][0] = 8'h01; llen[0] = 1; lflen[0] = 1;
        run_until_fd("s1", 1, 20, 0);
        chk("s1_count", ocnt, 3);
        chk("s1_b0", obytes[0], 8'h01);
        chk("s1_b1", obytes[1], 8'h80);
        chk("s1_b2", obytes[2], 8'h05);
        chk("s1_last0", olast[0], 1'b0);
        chk("s1_last2", olast[2], 1'b1);
        chk("s1_fd_timing", fd_cyc[0], ocyc[2] + 1);
        chk("s1_idle_busy", o_busy, 1'b0);
        cycle(0); cycle(0);
        chk("s1_fd_single_pulse", fd_cnt, 1);

        // 2: "123456789" from requester 2
        clear_log();
        load_check(2);
        run_until_fd("s2", 1, 40, 0);
        chk("s2_count", ocnt, 11);
        check_crc_frame("s2", 0, 2'd2);
        chk("s2_latency", fd_cyc[0], 12);
        chk("s2_stray", stray, 0);

        // 3: all four requesting from reset; round-robin 0,1,2,3,0
        rst = 1'b1; tick(); rst = 1'b0;
        clear_log();
        lbuf[0][0] = 8'hA0; lbuf[0][1] = 8'hA1; llen[0] = 2; lflen[0] = 1;
        lbuf[1][0] = 8'hB1; llen[1] = 1;
        lbuf[2][0] = 8'hC2; llen[2] = 1;
        lbuf[3][0] = 8'hD3; llen[3] = 1;
        run_until_fd("s3", 5, 60, 0);
        chk("s3_count", ocnt, 15);
        nlast = 0;
        for (int k = 0; k < ocnt; k++) begin
            if (olast[k]) begin
                if (nlast < 5) chk($sformatf("s3_grant%0d", nlast), osrc[k], exp_order[nlast]);
                nlast++;
            end
        end
        chk("s3_frames", nlast, 5);
        chk("s3_pay0", obytes[0], 8'hA0);
        chk("s3_pay1", obytes[3], 8'hB1);
        chk("s3_pay2", obytes[6], 8'hC2);
        chk("s3_pay3", obytes[9], 8'hD3);
        chk("s3_pay4", obytes[12], 8'hA1);
        chk("s3_one_idle_gap", ocyc[3] - ocyc[2], 2);
        chk("s3_stray", stray, 0);

        // 4: out_ready toggling every cycle
        clear_log();
        load_check(2);
        run_until_fd("s4", 1, 80, 1);
        chk("s4_count", ocnt, 11);
        check_crc_frame("s4", 0, 2'd2);
        chk("s4_stall_stable", stall_bad, 0);
        chk("s4_stray", stray, 0);

        // 5: reset while in CRC_HI abandons the frame
        clear_log();
        lbuf[0][0] = 8'h01; llen[0] = 1; lflen[0] = 1;
        for (int n = 0; n < 10 && ocnt < 1; n++) cycle(0);
        i_req_valid = '0; i_out_ready = 1'b0;
        #1;
        chk("s5_in_crc_hi", o_out_data, 8'h80);
        chk("s5_busy_before", o_busy, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0; i_out_ready = 1'b1;
        #1;
        chk("s5_req_ready",  o_req_ready, 4'b0);
        chk("s5_out_valid",  o_out_valid, 1'b0);
        chk("s5_out_last",   o_out_last, 1'b0);
        chk("s5_busy",       o_busy, 1'b0);
        chk("s5_frame_done", o_frame_done, 1'b0);
        chk("s5_out_src",    o_out_src, 2'd0);
        clear_log();
        load_check(1);
        run_until_fd("s5", 1, 40, 0);
        chk("s5_count", ocnt, 11);
        check_crc_frame("s5", 0, 2'd1);

        // 6: requester 3 stalls 5 cycles mid-frame while requester 0 waits
        clear_log();
        load_check(3);
        lbuf[0][0] = 8'h01; llen[0] = 1; lflen[0] = 1;
        for (int n = 0; n < 20 && lpos[3] < 3; n++) cycle(0);
        lhold[3] = 1'b1;
        for (int n = 0; n < 5; n++) cycle(0);
        lhold[3] = 1'b0;
        run_until_fd("s6", 2, 60, 0);
        chk("s6_count", ocnt, 14);
        check_crc_frame("s6", 0, 2'd3);
        chk("s6_gap", ocyc[3] - ocyc[2], 6);
        chk("s6_r0_b0", obytes[11], 8'h01);
        chk("s6_r0_b1", obytes[12], 8'h80);
        chk("s6_r0_b2", obytes[13], 8'h05);
        chk("s6_r0_src", osrc[11], 2'd0);
        chk("s6_stray", stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
